// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and decodes a raw push-button
// into a clean level plus press/release/long-press/auto-repeat pulses.
//
// Ports:
//   GCLK        in   system clock
//   rst         in   asynchronous reset, active-high
//   btn_in      in   raw button, asynchronous to GCLK
//   btn_level   out  debounced level
//   btn_press   out  1-cycle pulse on debounced 0->1
//   btn_release out  1-cycle pulse on debounced 1->0
//   btn_long    out  1-cycle pulse after LONG_CYCLES of hold
//   btn_repeat  out  1-cycle pulse every REPEAT_CYCLES after btn_long
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic GCLK,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic        s1;
  logic        s2;
  logic [31:0] deb_cnt;
  logic        differ;
  logic        deb_done;
  logic        rise;
  logic        fall;
  state_t      state;
  logic [31:0] hold_cnt;

  assign differ   = s2 != btn_level;
  assign deb_done = differ && (deb_cnt == DEB_LAST);
  // Level changes on the same edge these fire, so the hold FSM
  // tracks the new level without an extra cycle of lag.
  assign rise     = deb_done && s2;
  assign fall     = deb_done && !s2;

  always_ff @(posedge GCLK or posedge rst) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      deb_cnt     <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      btn_press   <= rise;
      btn_release <= fall;
      if (!differ || deb_done) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 32'd1;
      end
      if (deb_done) begin
        btn_level <= s2;
      end
    end
  end

  // Release takes priority over a coincident long/repeat terminal count.
  always_ff @(posedge GCLK or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      btn_long   <= 1'b0;
      btn_repeat <= 1'b0;
    end else begin
      btn_long   <= 1'b0;
      btn_repeat <= 1'b0;
      unique case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (rise) begin
            state <= PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt == LONG_LAST) begin
            state    <= HELD;
            hold_cnt <= '0;
            btn_long <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        HELD: begin
          if (fall) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt == REP_LAST) begin
            hold_cnt   <= '0;
            btn_repeat <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: self-checking bench for btn_conditioner.
// Expected pulses are queued with their cycle stamps and matched by a monitor.
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;

  localparam logic [3:0] EV_P  = 4'b0001;
  localparam logic [3:0] EV_R  = 4'b0010;
  localparam logic [3:0] EV_L  = 4'b0100;
  localparam logic [3:0] EV_RP = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } exp_t;

  logic GCLK;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;
  logic btn_repeat;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] mon_ev;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LNG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .GCLK(GCLK),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long),
    .btn_repeat(btn_repeat)
  );

  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  always @(posedge GCLK) cyc++;

  always @(negedge GCLK) begin
    mon_ev = {btn_repeat, btn_long, btn_release, btn_press};
    if (mon_ev != 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none",
                 cyc, mon_ev);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.ev !== mon_ev) begin
          errors++;
          $display("FAIL event got cyc=%0d ev=%b required cyc=%0d ev=%b",
                   cyc, mon_ev, mon_e.cyc, mon_e.ev);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge GCLK);
  endtask

  task automatic push(input int c, input logic [3:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 1'b0;
    #2;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=00000",
               {btn_level, btn_press, btn_release, btn_long, btn_repeat});
    end
    step(2);
    rst = 1'b0;
    step(2);
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_level got=%b required=0", btn_level);
    end
  endtask

  task automatic test_clean_step();
    int c;
    c      = cyc;
    btn_in = 1'b1;
    push(c + DEB + 2, EV_P);
    step(DEB + 1);
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL clean_level_early got=%b required=0", btn_level);
    end
    step(1);
    checks++;
    if (btn_level !== 1'b1) begin
      errors++;
      $display("FAIL clean_level_rise got=%b required=1", btn_level);
    end
    step(4);
    c      = cyc;
    btn_in = 1'b0;
    push(c + DEB + 2, EV_R);
    step(DEB + 2);
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL clean_level_fall got=%b required=0", btn_level);
    end
    step(4);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL clean_pending got=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_bounce();
    int   c;
    logic pat [9];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      btn_in = pat[i];
      step(1);
    end
    c      = cyc;
    btn_in = 1'b1;
    push(c + DEB + 2, EV_P);
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level_during got=%b required=0", btn_level);
    end
    step(DEB + 1);
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level_early got=%b required=0", btn_level);
    end
    step(1);
    checks++;
    if (btn_level !== 1'b1) begin
      errors++;
      $display("FAIL bounce_level_rise got=%b required=1", btn_level);
    end
    c      = cyc;
    btn_in = 1'b0;
    push(c + DEB + 2, EV_R);
    step(DEB + 6);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bounce_pending got=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_long_hold();
    int c;
    c      = cyc;
    btn_in = 1'b1;
    push(c + 6, EV_P);
    push(c + 6 + LNG, EV_L);
    for (int t = c + 6 + LNG + REP; t < c + 72; t += REP) push(t, EV_RP);
    push(c + 72, EV_R);
    step(66);
    checks++;
    if (btn_level !== 1'b1) begin
      errors++;
      $display("FAIL long_level_held got=%b required=1", btn_level);
    end
    btn_in = 1'b0;
    step(6 + 15);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL long_pending got=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_boundary();
    int c;
    c      = cyc;
    btn_in = 1'b1;
    push(c + 6, EV_P);
    push(c + 6 + LNG, EV_R);
    step(LNG);
    btn_in = 1'b0;
    step(6);
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL boundary_level got=%b required=0", btn_level);
    end
    step(10);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL boundary_pending got=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset();
    int c;
    int n;
    c      = cyc;
    btn_in = 1'b1;
    push(c + 6, EV_P);
    push(c + 6 + LNG, EV_L);
    step(6 + LNG + 2);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL areset_pre_pending got=%0d required=0", sb.size());
      sb.delete();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== 5'b0) begin
      errors++;
      $display("FAIL areset_outputs got=%b required=00000",
               {btn_level, btn_press, btn_release, btn_long, btn_repeat});
    end
    #2;
    rst = 1'b0;
    n   = cyc;
    push(n + 6, EV_P);
    push(n + 6 + LNG, EV_L);
    push(n + 6 + LNG + REP, EV_RP);
    push(n + 34, EV_R);
    step(28);
    btn_in = 1'b0;
    step(10);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL areset_pending got=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 100; i++) begin
      btn_in = (i % 3 == 0);
      step(1);
      if (i % 25 == 24) begin
        checks++;
        if (btn_level !== 1'b0) begin
          errors++;
          $display("FAIL glitch_level i=%0d got=%b required=0", i, btn_level);
        end
      end
    end
    btn_in = 1'b0;
    step(8);
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL glitch_level_end got=%b required=0", btn_level);
    end
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_long_hold();
    test_boundary();
    test_async_reset();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the raw, bouncing push-button input (BTNU) before it reaches the LED flasher and pattern logic.
- Synchronises the button into the GCLK domain, debounces it, and produces a clean level plus single-cycle event pulses: press, release, long-press and auto-repeat.
- Sits directly upstream of the LED flasher. Its outputs drive the flasher's control and reset inputs instead of the raw button.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised samples required to accept a new level (10 ms at 100 MHz).
- LONG_CYCLES, 100000000: cycles btn_level must stay 1 before btn_long fires (1 s).
- REPEAT_CYCLES, 25000000: btn_repeat period once long-press has fired (250 ms; matches the flasher step rate).

Ports:
- GCLK  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous reset, active-high.
- btn_in  input  1  raw button, asynchronous to GCLK, active-high when pressed.
- btn_level  output  1  debounced button level.
- btn_press  output  1  one-cycle pulse on the debounced 0->1 transition.
- btn_release  output  1  one-cycle pulse on the debounced 1->0 transition.
- btn_long  output  1  one-cycle pulse after LONG_CYCLES of continuous hold.
- btn_repeat  output  1  one-cycle pulse every REPEAT_CYCLES after btn_long, while still held.

Behaviour:
- Reset (rst=1, asynchronous, effective immediately, no clock needed):
  - all outputs 0;
  - synchroniser flops 0;
  - all counters 0;
  - FSM in IDLE.
  - Reset asserted mid-hold discards all history. After release of reset with the button still held, a full debounce period must elapse, and then btn_press fires as a fresh press.
- Synchroniser: two-flop chain btn_in -> s1 -> s2. s2 (btn_sync) is the only signal used downstream. btn_in is never used combinationally.
- Debounce counter (32-bit):
  - Cleared every cycle in which btn_sync == btn_level.
  - Incremented in every cycle in which they differ.
  - When it equals DEBOUNCE_CYCLES-1 while differing: btn_level <= btn_sync on that edge, and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never changes btn_level.
  - Latency: btn_level follows a clean btn_in step after exactly DEBOUNCE_CYCLES+2 GCLK edges.
- Event pulses:
  - btn_press and btn_release are registered. Each is high exactly during the first cycle in which btn_level shows its new value.
  - They are never high together and never high for more than one cycle.
- Hold FSM, states IDLE, PRESSED, HELD:
  - IDLE -> PRESSED on btn_level rising. The hold counter (32-bit) clears.
  - PRESSED:
    - The hold counter increments each cycle.
    - When it equals LONG_CYCLES-1, btn_long is high for the next cycle, the FSM moves to HELD, and the counter clears.
    - If btn_level falls first, the FSM returns to IDLE. btn_long never fires.
  - HELD:
    - The counter increments each cycle.
    - When it equals REPEAT_CYCLES-1, btn_repeat is high for the next cycle and the counter clears. This repeats indefinitely.
  - Release from PRESSED or HELD:
    - The FSM goes to IDLE and the hold counter clears.
    - btn_release pulses.
    - No btn_long or btn_repeat pulse may occur in the same cycle as btn_release or afterwards.
    - If the hold-count terminal value coincides with the falling edge of btn_level, the release wins and no long/repeat pulse fires.
- Timing relations:
  - btn_long is exactly LONG_CYCLES cycles after btn_press.
  - The first btn_repeat is exactly REPEAT_CYCLES cycles after btn_long.
- Counters wrap is impossible by construction: all are cleared at their terminal values. Parameters must be >= 2.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5):
- Clean step: btn_in 0->1, held. btn_level rises 6 cycles later, and btn_press pulses once in that same cycle. btn_in 1->0 gives btn_release 6 cycles after the step. No btn_long.
- Bounce: btn_in toggles with high pulses of 1, 2 and 3 cycles separated by 1-cycle lows, then stays 1. btn_level stays 0 through the bounce, then rises 6 cycles after the final rising edge. Exactly one btn_press.
- Long hold: btn_in held 1 for 60 cycles after btn_level rises. btn_long 20 cycles after btn_press. btn_repeat at +5, +10, +15 ... after btn_long. After release, no further btn_repeat, and one btn_release.
- Boundary: release timed so btn_level falls in the cycle the hold counter hits 19. btn_release fires, and btn_long never fires.
- Async reset mid-HELD: pulse rst for 3 ns between edges with btn_in still 1. All outputs drop to 0 immediately. After rst deasserts, btn_press reappears 6 cycles later and btn_long 20 cycles after that.
- Single-cycle glitches: 1-cycle btn_in pulses every 3 cycles for 100 cycles. btn_level stays 0, and no event pulses fire.
